// File: rtl/mem_stage_mc.sv
// Multi-cycle memory-access stage: one access per MEM_LAT cycles, stalls upstream while busy.
// Define MEM_STAGE_FWD_EN to compile in the WB->MEM load-to-store data forward.
module mem_stage_mc #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 9,
    parameter int unsigned MEM_LAT    = 4,
    parameter int unsigned REG_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [3:0]        req_opcode,
    input  logic [REG_W-1:0]  src_reg,
    input  logic [DATA_W-1:0] store_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wb_opcode,
    input  logic [REG_W-1:0]  wb_dst_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              fwd_hit
);

    localparam int unsigned ALIGN = $clog2(DATA_W / 8);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  fwd_hit_q, fwd_hit_d;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  fwd_cond;
    logic [DATA_W-1:0]     eff_data;
    logic                  accept;
    logic                  acc_en;
    logic                  acc_wr;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [DATA_W-1:0]     acc_data;

    // Upper address bits wrap; low ALIGN bits select a byte within the word and are ignored.
    assign req_idx = addr[ALIGN+DEPTH_LOG2-1:ALIGN];

`ifdef MEM_STAGE_FWD_EN
    localparam logic [3:0] OpLw = 4'b1000;
    localparam logic [3:0] OpSw = 4'b1001;

    assign fwd_cond = (req_opcode == OpSw) && (wb_opcode == OpLw) && (wb_dst_reg == src_reg);

    logic unused_addr;
    assign unused_addr = ^addr;
`else
    assign fwd_cond = 1'b0;

    logic unused_in;
    assign unused_in = ^{addr, req_opcode, src_reg, wb_opcode, wb_dst_reg, wb_data};
`endif

    assign eff_data = fwd_cond ? wb_data : store_data;
    assign accept   = (state_q == StIdle) && req_valid;

    // Single-cycle builds access straight from the request; otherwise from the latched copy.
    always_comb begin
        acc_en   = 1'b0;
        acc_wr   = wr_q;
        acc_idx  = idx_q;
        acc_data = data_q;
        if (MEM_LAT == 1) begin
            acc_en   = accept;
            acc_wr   = req_wr;
            acc_idx  = req_idx;
            acc_data = eff_data;
        end else begin
            acc_en = (state_q == StBusy) && (cnt_q == '0);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        data_d     = data_q;
        fwd_hit_d  = fwd_hit_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d      = req_wr;
                    idx_d     = req_idx;
                    data_d    = eff_data;
                    fwd_hit_d = fwd_cond;
                    if (MEM_LAT > 1) begin
                        state_d = StBusy;
                        cnt_d   = CNT_W'(MEM_LAT - 2);
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (acc_en && !acc_wr) begin
            rd_data_d  = mem[acc_idx];
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            fwd_hit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            fwd_hit_q  <= fwd_hit_d;
        end
    end

    // Contents survive reset; the rst gate keeps a held-in-reset request from writing.
    always_ff @(posedge clk) begin
        if (rst && acc_en && acc_wr) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign stall    = (accept && (MEM_LAT > 1)) || ((state_q == StBusy) && (cnt_q != '0));
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign fwd_hit  = fwd_hit_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Randomised scoreboard bench for mem_stage_mc: a MEM_LAT=4 instance plus a MEM_LAT=1 instance.
module tb_mem_stage_mc;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 512;
    localparam int LAT    = 4;
    localparam logic [3:0] OP_LW = 4'b1000;
    localparam logic [3:0] OP_SW = 4'b1001;
`ifdef MEM_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid, req_wr;
    logic [3:0]  req_opcode, src_reg, wb_opcode, wb_dst_reg;
    logic [15:0] store_data, addr, wb_data;
    logic        stall, rd_valid, fwd_hit;
    logic [15:0] rd_data;

    logic        l1_req_valid, l1_req_wr;
    logic [15:0] l1_store_data, l1_addr;
    logic        l1_stall, l1_rd_valid, l1_fwd_hit;
    logic [15:0] l1_rd_data;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] l1_ref  [DEPTH];
    exp_t        exp_q[$];
    exp_t        l1_q[$];
    exp_t        e_main, e_l1;

    mem_stage_mc #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(9), .MEM_LAT(LAT), .REG_W(4)
    ) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr),
        .req_opcode(req_opcode), .src_reg(src_reg), .store_data(store_data), .addr(addr),
        .wb_opcode(wb_opcode), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data),
        .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .fwd_hit(fwd_hit)
    );

    mem_stage_mc #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(9), .MEM_LAT(1), .REG_W(4)
    ) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(l1_req_valid), .req_wr(l1_req_wr),
        .req_opcode(4'b0000), .src_reg(4'h0), .store_data(l1_store_data), .addr(l1_addr),
        .wb_opcode(4'b0000), .wb_dst_reg(4'h1), .wb_data(16'h0000),
        .stall(l1_stall), .rd_data(l1_rd_data), .rd_valid(l1_rd_valid), .fwd_hit(l1_fwd_hit)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int word_of(input logic [15:0] a);
        return (int'(a) / (DATA_W / 8)) % DEPTH;
    endfunction

    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 data %0h, required no pulse", rd_data);
            end else begin
                e_main = exp_q.pop_front();
                check("rd_data", {16'h0, rd_data}, {16'h0, e_main.data});
                check("rd_cycle", cyc, e_main.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && l1_rd_valid) begin
            if (l1_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL l1_rd_unexpected: rd_valid=1 data %0h, required no pulse", l1_rd_data);
            end else begin
                e_l1 = l1_q.pop_front();
                check("l1_rd_data", {16'h0, l1_rd_data}, {16'h0, e_l1.data});
                check("l1_rd_cycle", cyc, e_l1.cyc);
            end
        end
    end

    // Issue one request and follow it to completion; model effects are applied at issue.
    task automatic do_req(input logic wr, input logic [3:0] op, input logic [3:0] src,
                          input logic [15:0] sdata, input logic [15:0] a,
                          input logic [3:0] wbop, input logic [3:0] wbdst,
                          input logic [15:0] wbdata, input bit perturb);
        bit          fwd;
        logic [15:0] eff;
        int          k, highs;
        bit          done;
        exp_t        ex;
        fwd = FWD && (op == OP_SW) && (wbop == OP_LW) && (wbdst == src);
        eff = fwd ? wbdata : sdata;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_opcode = op;
        src_reg    = src;
        store_data = sdata;
        addr       = a;
        wb_opcode  = wbop;
        wb_dst_reg = wbdst;
        wb_data    = wbdata;
        k = cyc;
        if (wr) begin
            ref_mem[word_of(a)] = eff;
        end else begin
            ex.data = ref_mem[word_of(a)];
            ex.cyc  = k + LAT;
            exp_q.push_back(ex);
        end
        highs = 0;
        done  = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (stall) begin
                highs++;
                @(posedge clk);
                #1;
                if (perturb) begin
                    addr       = 16'($urandom);
                    store_data = 16'($urandom);
                    wb_data    = 16'($urandom);
                    src_reg    = 4'($urandom);
                end
            end else begin
                done = 1'b1;
            end
        end
        check("stall_cycles", highs, LAT - 1);
        @(posedge clk);
        #1;
        check("fwd_hit", {31'h0, fwd_hit}, {31'h0, fwd});
        req_valid = 1'b0;
    endtask

    task automatic st(input logic [15:0] a, input logic [15:0] d, input bit perturb);
        do_req(1'b1, OP_SW, 4'h1, d, a, 4'h0, 4'h2, 16'h0, perturb);
    endtask

    task automatic ld(input logic [15:0] a, input bit perturb);
        do_req(1'b0, OP_LW, 4'h1, 16'h0, a, 4'h0, 4'h2, 16'h0, perturb);
    endtask

    initial begin
        logic [15:0] a, d;
        logic [3:0]  s;
        int          p;
        exp_t        ex;

        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_opcode = 4'h0; src_reg = 4'h0;
        store_data = 16'h0; addr = 16'h0; wb_opcode = 4'h0; wb_dst_reg = 4'h0; wb_data = 16'h0;
        l1_req_valid = 1'b0; l1_req_wr = 1'b0; l1_store_data = 16'h0; l1_addr = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("reset_rd_data", {16'h0, rd_data}, 32'h0);
        check("reset_fwd_hit", {31'h0, fwd_hit}, 32'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        st(16'h0010, 16'hBEEF, 1'b0);
        ld(16'h0010, 1'b0);

        do_req(1'b1, OP_SW, 4'h3, 16'h0000, 16'h0020, OP_LW, 4'h3, 16'h1234, 1'b0);
        ld(16'h0020, 1'b0);
        do_req(1'b1, OP_SW, 4'h3, 16'h7777, 16'h0022, OP_LW, 4'h4, 16'h1234, 1'b0);
        ld(16'h0022, 1'b0);

        st(16'h0402, 16'hA5A5, 1'b0);
        ld(16'h0002, 1'b0);
        ld(16'h0003, 1'b0);

        st(16'h0030, 16'hCAFE, 1'b1);
        ld(16'h0030, 1'b1);

        // Abort a store in its second cycle; memory must keep the old word.
        st(16'h0040, 16'h1111, 1'b0);
        req_valid = 1'b1; req_wr = 1'b1; req_opcode = OP_SW; src_reg = 4'h5;
        store_data = 16'h5555; addr = 16'h0040;
        wb_opcode = OP_LW; wb_dst_reg = 4'h5; wb_data = 16'h5555;
        @(posedge clk);
        #3;
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check("abort_stall", {31'h0, stall}, 32'h0);
        check("abort_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("abort_fwd_hit", {31'h0, fwd_hit}, 32'h0);
        check("abort_rd_data", {16'h0, rd_data}, 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        ld(16'h0040, 1'b0);

        for (int i = 0; i < 16; i++) begin
            st(16'(($urandom_range(0, 63) << 10) | (i << 1) | $urandom_range(0, 1)),
               16'($urandom), 1'b0);
        end
        for (int i = 0; i < 50; i++) begin
            p = $urandom_range(0, 15);
            a = 16'(($urandom_range(0, 63) << 10) | (p << 1) | $urandom_range(0, 1));
            d = 16'($urandom);
            s = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1)
                    do_req(1'b1, OP_SW, s, d, a, OP_LW, s, 16'($urandom),
                           bit'($urandom_range(0, 1)));
                else
                    do_req(1'b1, OP_SW, s, d, a, 4'($urandom), 4'($urandom), 16'($urandom),
                           bit'($urandom_range(0, 1)));
            end else begin
                ld(a, bit'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 8; i++) begin
            p = i / 2;
            l1_req_valid = 1'b1;
            l1_addr = 16'(($urandom_range(0, 63) << 10) | (p << 1) | $urandom_range(0, 1));
            if (i % 2 == 0) begin
                l1_req_wr = 1'b1;
                l1_store_data = 16'($urandom);
                l1_ref[p] = l1_store_data;
            end else begin
                l1_req_wr = 1'b0;
                ex.data = l1_ref[p];
                ex.cyc  = cyc + 1;
                l1_q.push_back(ex);
            end
            @(negedge clk);
            check("l1_stall", {31'h0, l1_stall}, 32'h0);
            @(posedge clk);
            #1;
        end
        l1_req_valid = 1'b0;

        for (int i = 0; i < 20 && (exp_q.size() != 0 || l1_q.size() != 0); i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_main", exp_q.size(), 0);
        check("drain_l1", l1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_mc.md
# mem_stage_mc

Parametrised, multi-cycle successor to the pipeline's memory-access stage.
- Owns a DATA_W-wide, 2^DEPTH_LOG2-entry data memory with configurable access latency.
- Stalls upstream stages while an access is in flight.
- Forwards a load result from WB into the store-data path (load→store hazard).
- Sits between the EX/MEM and MEM/WB pipeline registers and produces a registered load result with a one-cycle valid pulse.

## Interface
Parameters:
- DATA_W, 16, data and store width in bits; multiple of 8, ≥8.
- ADDR_W, 16, byte-address width.
- DEPTH_LOG2, 9, log2 of memory depth in words.
- MEM_LAT, 4, cycles per access; ≥1.
- REG_W, 4, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  memory access requested (load or store).
- req_wr  in  1  1 = store, 0 = load.
- req_opcode  in  4  opcode of the instruction in MEM.
- src_reg  in  REG_W  source register supplying the store data.
- store_data  in  DATA_W  store data read from the register file.
- addr  in  ADDR_W  byte address computed by the ALU.
- wb_opcode  in  4  opcode of the instruction in WB.
- wb_dst_reg  in  REG_W  destination register of the instruction in WB.
- wb_data  in  DATA_W  load result currently in WB.
- stall  out  1  hold the upstream pipeline.
- rd_data  out  DATA_W  registered load result.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- fwd_hit  out  1  registered; the accepted store used forwarded data.

## Operation
- Word index: addr[ALIGN+DEPTH_LOG2-1 : ALIGN], where ALIGN = log2(DATA_W/8).
  - Low ALIGN bits are ignored.
  - Address bits above the index are ignored, so addresses wrap modulo the depth.
- Forwarding condition: req_opcode==4'b1001 (SW), wb_opcode==4'b1000 (LW), and wb_dst_reg==src_reg.
  - When true, the effective store data is wb_data; otherwise it is store_data.
  - The condition is evaluated only in the acceptance cycle.
- FSM states:
  - IDLE: on req_valid, latch req_wr, the word index and the effective store data, and set fwd_hit.
    - MEM_LAT==1: perform the access at this edge and stay in IDLE.
    - MEM_LAT>1: load cnt=MEM_LAT-2 and go to BUSY.
  - BUSY: decrement cnt each edge. When cnt==0, perform the latched access at that edge and return to IDLE.
- Access behaviour:
  - Store: mem[idx] <= latched data; rd_valid stays 0.
  - Load: rd_data <= mem[idx] and rd_valid <= 1 for exactly one cycle.
- stall is combinational: (IDLE & req_valid & MEM_LAT>1) | (BUSY & cnt!=0).
- Upstream must hold all request inputs stable while stall=1. Input changes during BUSY are ignored because the access uses latched values.
- A request is accepted only in IDLE; req_valid in BUSY never starts a second access.

## Timing
- Reset (rst=0, at any time) drives:
  - state=IDLE, cnt=0, stall=0;
  - rd_data=0, rd_valid=0, fwd_hit=0.
- Reset mid-access aborts the access; an in-flight store is not written.
- Memory contents are not reset.
- Access latency: the acceptance edge plus MEM_LAT-1 BUSY cycles, so the access occupies MEM_LAT cycles and stall is high for the first MEM_LAT-1 of them.
- Load result: rd_data and rd_valid appear in the cycle after the completing edge.
- Back-to-back requests: the next request is accepted in the cycle after completion, giving one access per MEM_LAT cycles.
- A load to an address being written by the immediately preceding store returns the new data.
- Read-during-write to the same index is impossible, because only one access is in flight.

## Configuration
- MEM_STAGE_FWD_EN defined:
  - The WB→MEM store-data forward above is compiled in.
  - fwd_hit reflects the forwarding condition at acceptance.
- MEM_STAGE_FWD_EN undefined:
  - Effective store data is always store_data.
  - fwd_hit is tied to 0.
  - The wb_* inputs are unused.

## Test plan
1. Reset, then store 16'hBEEF to addr 16'h0010 and load from 16'h0010 (MEM_LAT=4):
   - stall is high for 3 cycles per access;
   - rd_valid pulses once, 4 cycles after load acceptance, with rd_data=16'hBEEF.
2. Forwarding, with MEM_STAGE_FWD_EN defined: SW with src_reg=3 while WB holds LW, wb_dst_reg=3, wb_data=16'h1234, and store_data=16'h0000.
   - fwd_hit=1.
   - A subsequent load of that address returns 16'h1234.
   - Without the macro, the same load returns 16'h0000.
3. Wrap-around (DEPTH_LOG2=9): store 16'hA5A5 to addr 16'h0402, then load from 16'h0002.
   - The load returns 16'hA5A5.
   - Low bit 1 vs 0 aliases to the same word.
4. Reset during BUSY: assert rst=0 in the 2nd cycle of a store of 16'h5555 to a location holding 16'h1111, then load it.
   - stall, rd_valid and fwd_hit read 0 immediately on reset.
   - The load returns 16'h1111.
5. MEM_LAT=1 build: alternate stores and loads every cycle for 8 cycles.
   - stall never asserts.
   - Each load gives rd_valid the next cycle with the correct data.
6. Change addr and store_data while stall=1.
   - The access still uses the values latched at acceptance.
